// File: rtl/fetch_queue.sv
// Instruction-granular fetch queue: compacts masked fetch packets into a circular
// buffer and presents the oldest PIPE_WIDTH instructions to the decoder.
module fetch_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int PIPE_WIDTH  = 2,
    parameter int DEPTH       = 8,
    parameter int ADDR_BITS   = 32,
    parameter int INST_BITS   = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               fetch_val,
    input  logic [ADDR_BITS-1:0]               fetch_pc,
    input  logic [FETCH_WIDTH*INST_BITS-1:0]   fetch_insts,
    input  logic [FETCH_WIDTH-1:0]             fetch_mask,
    output logic                               fetch_rdy,
    output logic [PIPE_WIDTH*INST_BITS-1:0]    out_insts,
    output logic [PIPE_WIDTH*ADDR_BITS-1:0]    out_pcs,
    output logic [PIPE_WIDTH-1:0]              out_val,
    input  logic [$clog2(PIPE_WIDTH+1)-1:0]    dec_take,
    output logic [$clog2(DEPTH+1)-1:0]         count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] PIPE_CNT  = CW'(PIPE_WIDTH);
    localparam logic [CW-1:0] FETCH_CNT = CW'(FETCH_WIDTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [PW-1:0]        rdPtr_q, rdPtr_d;
    logic [PW-1:0]        wrPtr_q, wrPtr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [INST_BITS-1:0] instMem_q [DEPTH];
    logic [ADDR_BITS-1:0] pcMem_q   [DEPTH];

    logic                 writeEn;
    logic [CW-1:0]        nWrite;
    logic [CW-1:0]        nRead;
    logic [CW-1:0]        avail;
    logic [CW-1:0]        takeClamped;
    logic [PW-1:0]        slotIdx [FETCH_WIDTH];

    assign fetch_rdy = (DEPTH_CNT - cnt_q) >= FETCH_CNT;
    assign count     = cnt_q;

    // Each valid slot lands at wrPtr plus the number of valid slots below it.
    always_comb begin
        writeEn = fetch_val && fetch_rdy && !flush;
        nWrite  = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slotIdx[i] = wrPtr_q + nWrite[PW-1:0];
            if (fetch_mask[i]) begin
                nWrite = nWrite + CW'(1);
            end
        end
    end

    always_comb begin
        avail       = (cnt_q < PIPE_CNT) ? cnt_q : PIPE_CNT;
        takeClamped = (CW'(dec_take) < avail) ? CW'(dec_take) : avail;
        nRead       = flush ? '0 : takeClamped;
        out_val     = '0;
        out_insts   = '0;
        out_pcs     = '0;
        for (int k = 0; k < PIPE_WIDTH; k++) begin
            if ((CW'(k) < avail) && !flush) begin
                out_val[k]                        = 1'b1;
                out_insts[k*INST_BITS +: INST_BITS] = instMem_q[PW'(rdPtr_q + PW'(k))];
                out_pcs[k*ADDR_BITS +: ADDR_BITS]   = pcMem_q[PW'(rdPtr_q + PW'(k))];
            end
        end
    end

    always_comb begin
        rdPtr_d = rdPtr_q + nRead[PW-1:0];
        wrPtr_d = writeEn ? (wrPtr_q + nWrite[PW-1:0]) : wrPtr_q;
        cnt_d   = cnt_q + (writeEn ? nWrite : '0) - nRead;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            cnt_q   <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Entry contents survive a flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                instMem_q[e] <= '0;
                pcMem_q[e]   <= '0;
            end
        end else if (writeEn) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (fetch_mask[i]) begin
                    instMem_q[slotIdx[i]] <= fetch_insts[i*INST_BITS +: INST_BITS];
                    pcMem_q[slotIdx[i]]   <= fetch_pc + ADDR_BITS'(4*i);
                end
            end
        end
    end

    // A decoder asking for more than is shown is a protocol slip; the read is clamped.
    always @(posedge clk) begin
        if (!rst && !flush) begin
            assert (CW'(dec_take) <= avail)
            else $warning("dec_take exceeds available instructions; clamped");
        end
    end

endmodule
